// File: rtl/waitstate_datamem.sv
// waitstate_datamem: data memory with wait states for the cpu data port.
// A request is captured in IDLE and held for LATENCY edges. A one-cycle
// mem_ready pulse then completes it, and mem_error flags a rejected request.
// Optional feature macro: WAITMEM_BYTE_STROBE_EN adds a byte_en write strobe.
// The memory array itself is not reset.
module waitstate_datamem #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
`ifdef WAITMEM_BYTE_STROBE_EN
  input  logic [3:0]  byte_en,
`endif
  output logic [31:0] readdata,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_is_write;
  logic          r_err;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_readdata;
  logic          r_ready;
  logic          r_error;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_accept;
  logic          w_err_now;
  logic          w_commit;
  logic [3:0]    w_be;

`ifdef WAITMEM_BYTE_STROBE_EN
  assign w_be = byte_en;
`else
  assign w_be = 4'hF;
`endif

  assign w_req     = memread | memwrite;
  assign w_accept  = (r_state == S_IDLE) && w_req;
  // The request is rejected if it is conflicting, misaligned or beyond the array.
  assign w_err_now = (memread & memwrite) | (addr[1:0] != 2'b00) | (|addr[31:AW+2]);
  // The edge leaving BUSY (entering RESP) is the single commit point.
  assign w_commit  = (r_state == S_BUSY) && (r_cnt == 4'd0);

  // Sequence the request and capture the inputs at accept.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_is_write <= 1'b0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_be       <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_write <= memwrite;
            r_err      <= w_err_now;
            r_idx      <= addr[AW+1:2];
            r_wdata    <= writedata;
            r_be       <= w_be;
            r_cnt      <= 4'(LATENCY - 1);
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Raise the response flags and load read data on the edge that enters RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_ready <= w_commit;
      r_error <= w_commit & r_err;
      if (w_commit && !r_err && !r_is_write) begin
        r_readdata <= r_mem[r_idx];
      end
    end
  end

  // Commit the write into the array lane by lane.
  // NOTE: the array has no reset, so it keeps its contents through reset and maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_commit && !r_err && r_is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign readdata  = r_readdata;
  assign mem_ready = r_ready;
  assign mem_error = r_error;

endmodule
